// File: rtl/multicycle_control.sv
// Control FSM for the shared multicycle datapath (one memory, one ALU), full ISA incl. link/branch ops.
// Latency: outputs decode the current state in the same cycle; 3-5 cycles per instruction plus memory stalls.
// Backpressure: FETCH/MEMRD/MEMWR hold with access strobes steady until mem_ready is sampled high.
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             mem_ready,
   input  logic             cond_taken,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             regwrite,
   output logic             memtoreg,
   output logic             regdest,
   output logic             link_sel,
   output logic             alusrc_a,
   output logic [1:0]       alusrc_b,
   output logic [1:0]       aluop,
   output logic [1:0]       pc_source,
   output logic [2:0]       branch_type,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_BMVBR  = 4'd9,
      S_JALPC  = 4'd10,
      S_LINK   = 4'd11
   } state_t;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BMV   = 6'b010110;
   localparam logic [5:0] OP_BALN  = 6'b100000;
   localparam logic [5:0] OP_JALPC = 6'b011111;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BLEZ  = 6'b000110;
   localparam logic [5:0] OP_BNEAL = 6'b101101;
   localparam logic [5:0] FN_BALRN = 6'b011000;

   state_t state_q, state_d;
   logic   retire;

   logic is_r, is_balrn, is_ori, is_lw, is_sw, is_bmv;
   logic is_beq, is_blez, is_baln, is_bneal, is_jalpc;

   assign is_r     = (opcode == OP_R);
   assign is_balrn = is_r && (funct == FN_BALRN);
   assign is_ori   = (opcode == OP_ORI);
   assign is_lw    = (opcode == OP_LW);
   assign is_sw    = (opcode == OP_SW);
   assign is_bmv   = (opcode == OP_BMV);
   assign is_beq   = (opcode == OP_BEQ);
   assign is_blez  = (opcode == OP_BLEZ);
   assign is_baln  = (opcode == OP_BALN);
   assign is_bneal = (opcode == OP_BNEAL);
   assign is_jalpc = (opcode == OP_JALPC);

   assign state = state_q;

   // State register and retired-instruction counter; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FETCH;
         instr_count <= '0;
      end else begin
         state_q <= state_d;
         if (retire)
            instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Next-state and strobe decode; every output held low while reset is asserted.
   always_comb begin
      state_d       = state_q;
      retire        = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      regwrite      = 1'b0;
      memtoreg      = 1'b0;
      regdest       = 1'b0;
      link_sel      = 1'b0;
      alusrc_a      = 1'b0;
      alusrc_b      = 2'b00;
      aluop         = 2'b00;
      pc_source     = 2'b00;
      branch_type   = 3'd0;
      illegal       = 1'b0;
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               mem_read = 1'b1;
               alusrc_b = 2'b01;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_d  = S_DECODE;
               end
            end
            S_DECODE: begin
               alusrc_b = 2'b11;
               if ((is_r && !is_balrn) || is_ori)
                  state_d = S_EXEC;
               else if (is_lw || is_sw || is_bmv)
                  state_d = S_MEMADR;
               else if (is_beq || is_blez || is_baln || is_bneal || is_balrn)
                  state_d = S_BRANCH;
               else if (is_jalpc)
                  state_d = S_JALPC;
               else begin
                  // Undefined opcode: drop it without counting it as retired.
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            end
            S_MEMADR: begin
               alusrc_a = 1'b1;
               alusrc_b = 2'b10;
               state_d  = is_sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
               if (mem_ready)
                  state_d = is_bmv ? S_BMVBR : S_MEMWB;
            end
            S_MEMWB: begin
               regwrite = 1'b1;
               memtoreg = 1'b1;
               state_d  = S_FETCH;
               retire   = 1'b1;
            end
            S_MEMWR: begin
               mem_write = 1'b1;
               iord      = 1'b1;
               if (mem_ready) begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
            end
            S_EXEC: begin
               alusrc_a = 1'b1;
               if (is_ori) begin
                  alusrc_b = 2'b10;
                  aluop    = 2'b11;
               end else begin
                  alusrc_b = 2'b00;
                  aluop    = 2'b10;
               end
               state_d = S_RWB;
            end
            S_RWB: begin
               regwrite = 1'b1;
               regdest  = is_r;
               state_d  = S_FETCH;
               retire   = 1'b1;
            end
            S_BRANCH: begin
               alusrc_a      = 1'b1;
               aluop         = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
               if (is_balrn)      branch_type = 3'd5;
               else if (is_bneal) branch_type = 3'd3;
               else if (is_baln)  branch_type = 3'd2;
               else if (is_blez)  branch_type = 3'd1;
               else               branch_type = 3'd0;
               // Linking branches spend one extra cycle writing the return address.
               if (cond_taken && (is_baln || is_bneal || is_balrn)) begin
                  state_d = S_LINK;
               end else begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
            end
            S_BMVBR: begin
               pc_write_cond = 1'b1;
               pc_source     = 2'b11;
               branch_type   = 3'd4;
               state_d       = S_FETCH;
               retire        = 1'b1;
            end
            S_JALPC: begin
               regwrite  = 1'b1;
               link_sel  = 1'b1;
               pc_write  = 1'b1;
               pc_source = 2'b10;
               state_d   = S_FETCH;
               retire    = 1'b1;
            end
            S_LINK: begin
               regwrite = 1'b1;
               link_sel = 1'b1;
               regdest  = is_balrn;
               state_d  = S_FETCH;
               retire   = 1'b1;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

   localparam int CW = 4;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BMV   = 6'b010110;
   localparam logic [5:0] OP_BALN  = 6'b100000;
   localparam logic [5:0] OP_JALPC = 6'b011111;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BLEZ  = 6'b000110;
   localparam logic [5:0] OP_BNEAL = 6'b101101;
   localparam logic [5:0] FN_BALRN = 6'b011000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [5:0]    opcode;
   logic [5:0]    funct;
   logic          mem_ready;
   logic          cond_taken;
   logic          pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic          regwrite, memtoreg, regdest, link_sel, alusrc_a;
   logic [1:0]    alusrc_b, aluop, pc_source;
   logic [2:0]    branch_type;
   logic          illegal;
   logic [3:0]    state;
   logic [CW-1:0] instr_count;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   multicycle_control #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
      .mem_ready(mem_ready), .cond_taken(cond_taken),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .regwrite(regwrite), .memtoreg(memtoreg), .regdest(regdest),
      .link_sel(link_sel), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
      .aluop(aluop), .pc_source(pc_source), .branch_type(branch_type),
      .illegal(illegal), .state(state), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   wire [20:0] obs_vec = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                          regwrite, memtoreg, regdest, link_sel, alusrc_a,
                          alusrc_b, aluop, pc_source, branch_type, illegal};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BMV, OP_BALN,
                        OP_JALPC, OP_ORI, OP_BLEZ, OP_BNEAL};
   endfunction

   // Expected output vector straight from the per-state output table.
   function automatic logic [20:0] exp_vec(input int st, input logic rdy);
      logic pcw = 0, pcwc = 0, io = 0, mr = 0, mw = 0, irw = 0, rw = 0, m2r = 0;
      logic rd = 0, ls = 0, asa = 0, ill = 0;
      logic [1:0] bsel = 0, aop = 0, psrc = 0;
      logic [2:0] bt = 0;
      logic isr = (opcode == OP_R);
      logic isbalrn = isr && (funct == FN_BALRN);
      case (st)
         0: begin mr = 1; bsel = 2'b01; if (rdy) begin irw = 1; pcw = 1; end end
         1: begin bsel = 2'b11; ill = !is_legal(opcode); end
         2: begin asa = 1; bsel = 2'b10; end
         3: begin mr = 1; io = 1; end
         4: begin rw = 1; m2r = 1; end
         5: begin mw = 1; io = 1; end
         6: begin
            asa = 1;
            if (opcode == OP_ORI) begin bsel = 2'b10; aop = 2'b11; end
            else begin bsel = 2'b00; aop = 2'b10; end
         end
         7: begin rw = 1; rd = isr; end
         8: begin
            asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01;
            if (isbalrn) bt = 5;
            else if (opcode == OP_BLEZ) bt = 1;
            else if (opcode == OP_BALN) bt = 2;
            else if (opcode == OP_BNEAL) bt = 3;
            else bt = 0;
         end
         9: begin pcwc = 1; psrc = 2'b11; bt = 4; end
         10: begin rw = 1; ls = 1; pcw = 1; psrc = 2'b10; end
         11: begin rw = 1; ls = 1; rd = isbalrn; end
         default: ;
      endcase
      return {pcw, pcwc, io, mr, mw, irw, rw, m2r, rd, ls, asa, bsel, aop, psrc, bt, ill};
   endfunction

   // One clock cycle: drive mem_ready, check state and outputs, advance to just after the edge.
   task automatic cyc(input int st, input logic rdy);
      mem_ready = rdy;
      #1;
      chk($sformatf("state(exp %0d)", st), 32'(state), 32'(st));
      chk($sformatf("outputs in state %0d", st), 32'(obs_vec), 32'(exp_vec(st, rdy)));
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction through the expected state path with given stall counts.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic cond,
                            input int sf, input int sm);
      int path[$];
      bit linking;
      opcode = op;
      funct = fn;
      cond_taken = cond;
      linking = (op == OP_BALN) || (op == OP_BNEAL) || (op == OP_R && fn == FN_BALRN);
      if (op == OP_R && fn == FN_BALRN) path = {0, 1, 8};
      else if (op == OP_R || op == OP_ORI) path = {0, 1, 6, 7};
      else if (op == OP_LW) path = {0, 1, 2, 3, 4};
      else if (op == OP_SW) path = {0, 1, 2, 5};
      else if (op == OP_BMV) path = {0, 1, 2, 3, 9};
      else if (op == OP_JALPC) path = {0, 1, 10};
      else if (op == OP_BEQ || op == OP_BLEZ || linking) path = {0, 1, 8};
      else path = {0, 1};
      if (linking && cond) path.push_back(11);
      foreach (path[i]) begin
         if (path[i] == 0) begin
            repeat (sf) cyc(0, 1'b0);
            cyc(0, 1'b1);
         end else if (path[i] == 3 || path[i] == 5) begin
            repeat (sm) cyc(path[i], 1'b0);
            cyc(path[i], 1'b1);
         end else begin
            cyc(path[i], 1'($urandom_range(0, 1)));
         end
      end
      if (is_legal(op)) exp_cnt = (exp_cnt + 1) % (1 << CW);
      chk("instr_count", 32'(instr_count), 32'(exp_cnt));
   endtask

   // Store that is reset while waiting on memory: everything must drop immediately.
   task automatic reset_mid_store();
      opcode = OP_SW;
      funct = 6'd0;
      cond_taken = 1'b0;
      cyc(0, 1'b1);
      cyc(1, 1'b1);
      cyc(2, 1'b1);
      mem_ready = 1'b0;
      #1;
      chk("pre-reset state", 32'(state), 32'd5);
      chk("pre-reset mem_write", 32'(mem_write), 32'd1);
      rst_n = 1'b0;
      #1;
      exp_cnt = 0;
      chk("reset state", 32'(state), 32'd0);
      chk("reset mem_write", 32'(mem_write), 32'd0);
      chk("reset instr_count", 32'(instr_count), 32'd0);
      chk("reset outputs", 32'(obs_vec), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [5:0] ops[10];
      logic [5:0] op;
      logic [5:0] fn;
      ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BMV, OP_BALN, OP_JALPC, OP_ORI, OP_BLEZ, OP_BNEAL};
      rst_n = 1'b0;
      mem_ready = 1'b1;
      cond_taken = 1'b0;
      opcode = OP_LW;
      funct = 6'd0;
      @(posedge clk);
      #1;
      chk("in-reset state", 32'(state), 32'd0);
      chk("in-reset outputs", 32'(obs_vec), 32'd0);
      chk("in-reset instr_count", 32'(instr_count), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_instr(OP_LW, 6'd0, 1'b0, 3, 3);
      run_instr(OP_R, 6'b100000, 1'b0, 0, 0);
      run_instr(OP_ORI, 6'd0, 1'b0, 0, 0);
      run_instr(OP_BNEAL, 6'd0, 1'b1, 0, 0);
      run_instr(OP_BNEAL, 6'd0, 1'b0, 0, 0);
      run_instr(OP_BMV, 6'd0, 1'b0, 0, 0);
      run_instr(OP_JALPC, 6'd0, 1'b0, 0, 0);
      run_instr(6'b111111, 6'd0, 1'b0, 0, 0);
      run_instr(OP_R, FN_BALRN, 1'b1, 1, 0);
      run_instr(OP_BALN, 6'd0, 1'b1, 0, 0);
      run_instr(OP_BEQ, 6'd0, 1'b1, 0, 0);
      run_instr(OP_BLEZ, 6'd0, 1'b1, 0, 0);
      run_instr(OP_SW, 6'd0, 1'b0, 2, 2);
      // Enough retirements to carry the 4-bit counter through 15 -> 0.
      repeat (10) run_instr(OP_JALPC, 6'd0, 1'b0, 0, 0);
      reset_mid_store();

      for (int n = 0; n < 300; n++) begin
         fn = 6'($urandom);
         case ($urandom_range(0, 11))
            10: begin op = OP_R; fn = FN_BALRN; end
            11: begin
               op = 6'($urandom);
               while (is_legal(op)) op = 6'($urandom);
            end
            default: op = ops[$urandom_range(0, 9)];
         endcase
         run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
      end
      reset_mid_store();
      run_instr(OP_LW, 6'd0, 1'b0, 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
